rom_arbiter: RTL
================

# rom_arbiter

Arbitrates a single-port instruction ROM between the instruction-fetch requester (PC/fetch path) and the load/store-stage requester, which reads constants and literal pools.
- Issues at most one ROM read per cycle.
- Tracks in-flight reads through a fixed-latency tag pipeline and routes returned data to its owner.
- Raises a hold toward the PC when fetch loses arbitration, so the fetch stage injects NOP bubbles instead of stale instructions.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- RD_LAT, 1, ROM read latency in cycles (legal 1..3)
- STARVE_MAX, 4, consecutive fetch denials before forced fetch grant (only used with ROM_ARB_FAIR_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  AW  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DW  fetch instruction; `INST_NOP when if_rvalid_o=0
- ls_req_i  in  1  load-stage read request
- ls_addr_i  in  AW  load-stage address
- ls_gnt_o  out  1  load request accepted
- ls_rvalid_o  out  1  load data valid
- ls_rdata_o  out  DW  load data; 0 when ls_rvalid_o=0
- flush_i  in  1  pipeline flush; kills in-flight fetch reads
- rom_en_o  out  1  ROM read enable
- rom_addr_o  out  AW  ROM address
- rom_rdata_i  in  DW  ROM data, valid RD_LAT cycles after rom_en_o
- hold_if_o  out  1  hold PC/fetch (if_req_i & ~if_gnt_o)

## Operation
- Grant is combinational from the current requests and the starve counter. Exactly one of if_gnt_o/ls_gnt_o is high when any request is present.
- Default priority is ls > if.
- rom_en_o = if_gnt_o | ls_gnt_o. rom_addr_o is muxed from the granted requester and is 0 when idle.
- Each grant pushes {valid, owner} into an RD_LAT-deep tag shift register. The stage-RD_LAT entry selects the data destination:
  - owner IF: if_rvalid_o=1, if_rdata_o=rom_rdata_i
  - owner LS: ls_rvalid_o=1, ls_rdata_o=rom_rdata_i
- flush_i clears the valid bit of every in-flight IF tag in the same cycle, including a tag being pushed that cycle, and suppresses if_gnt_o that cycle. No IF data is delivered for pre-flush requests. LS tags are unaffected by flush_i.
- hold_if_o is high whenever fetch requests and is not granted, including during flush.

## Timing
- Request-to-grant: 0 cycles, combinational.
- Grant-to-rvalid: exactly RD_LAT cycles. Back-to-back grants yield back-to-back rvalids with no bubble.
- Simultaneous if_req_i and ls_req_i: LS granted, IF held. IF is granted the next cycle LS does not request (or per fair rule).
- Reset (asserted or mid-operation): tag pipeline invalid, starve counter 0. All valids, grants and hold are 0; ls_rdata_o=0, if_rdata_o=`INST_NOP, rom_addr_o=0. Outstanding reads are discarded, and data returned after reset release is ignored.

## Configuration
- ROM_ARB_FAIR_EN defined:
  - A saturating counter increments each cycle IF is denied by LS, and clears on an IF grant or when if_req_i=0.
  - When the counter reaches STARVE_MAX, IF wins the next contested cycle and LS is held.
- Undefined: strict ls > if priority, no counter is instantiated, and IF may starve indefinitely.

## Structure
- `INST_NOP (32'h00000013) comes from the shared instruction-defines header.
- Owner encodings OWN_IF=1'b0 and OWN_LS=1'b1 are added to that header.
- One sub-module, arb_tag_pipe: parameterised RD_LAT-deep {valid, owner} shift register with async active-low clear and per-owner kill input.

## Test plan
- RD_LAT=1, if_req_i steady at addr 0x0,0x4,0x8 → rom_addr_o follows same cycle; if_rvalid_o high one cycle later with matching ROM words; hold_if_o=0.
- Both request at cycle 5 (if 0x10, ls 0x100) → ls_gnt_o=1, hold_if_o=1; ls_rvalid_o at cycle 6 with word@0x100; IF granted cycle 6, if_rvalid_o at cycle 7.
- RD_LAT=3, IF grants cycles 0–2, flush_i at cycle 2 → no if_rvalid_o at cycles 3–5; if_rdata_o=`INST_NOP throughout.
- ROM_ARB_FAIR_EN, STARVE_MAX=4, both request continuously → pattern LS,LS,LS,LS,IF repeating.
- Same stimulus without macro → IF never granted; hold_if_o stays 1.
- rst driven low for one cycle with 2 reads in flight (RD_LAT=2) → all outputs at reset values immediately; no rvalid after release until new grants.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared instruction defines and tag-owner encodings for the ROM arbiter.
// Provides `INST_NOP, the fetch bubble injected whenever no fetch data is valid.
`ifndef INST_NOP
`define INST_NOP 32'h00000013
`endif

package rom_arbiter_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [31:0] INST_NOP_WORD = `INST_NOP;
  localparam int          RD_LAT_MAX    = 3;

endpackage

// File: rtl/arb_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift register tracking in-flight ROM reads.
// kill clears the valid bit of every entry (including the one being pushed) owned by kill_owner.
module arb_tag_pipe
  import rom_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_valid,
  input  owner_e push_owner,
  input  logic   kill,
  input  owner_e kill_owner,
  output logic   out_valid,
  output owner_e out_owner
);

  logic [RD_LAT-1:0] vld;
  owner_e            own [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) own[i] <= OWN_IF;
    end else begin
      vld[0] <= push_valid & ~(kill && (push_owner == kill_owner));
      own[0] <= push_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1] & ~(kill && (own[i-1] == kill_owner));
        own[i] <= own[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_owner = own[RD_LAT-1];

endmodule

// File: rtl/rom_arbiter.sv
// Single-port instruction ROM arbiter: load/store over fetch, fixed-latency data return routing.
// Optional starvation guard for fetch is enabled with `define ROM_ARB_FAIR_EN.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          ls_req_i,
  input  logic [AW-1:0] ls_addr_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [DW-1:0] ls_rdata_o,
  input  logic          flush_i,
  output logic          rom_en_o,
  output logic [AW-1:0] rom_addr_o,
  input  logic [DW-1:0] rom_rdata_i,
  output logic          hold_if_o
);

  // Out-of-range parameters instantiate a module that does not exist, stopping elaboration.
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX || STARVE_MAX < 1) begin : g_bad_param
    rom_arbiter_illegal_parameter u_bad_param ();
  end

  logic   force_if;
  logic   tag_valid;
  owner_e tag_owner;

`ifdef ROM_ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req_i || if_gnt_o) begin
      starve_cnt <= '0;
    end else if (ls_gnt_o && !flush_i && (starve_cnt != CW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_if = (starve_cnt == CW'(STARVE_MAX));
`else
  assign force_if = 1'b0;
`endif

  // Grants are forced low while reset is asserted so nothing reaches the ROM.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (rst) begin
      if_gnt_o = if_req_i & ~flush_i & (~ls_req_i | force_if);
      ls_gnt_o = ls_req_i & ~if_gnt_o;
    end
  end

  assign hold_if_o  = rst & if_req_i & ~if_gnt_o;
  assign rom_en_o   = if_gnt_o | ls_gnt_o;
  assign rom_addr_o = if_gnt_o ? if_addr_i : (ls_gnt_o ? ls_addr_i : '0);

  arb_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst),
    .push_valid(rom_en_o),
    .push_owner(ls_gnt_o ? OWN_LS : OWN_IF),
    .kill      (flush_i),
    .kill_owner(OWN_IF),
    .out_valid (tag_valid),
    .out_owner (tag_owner)
  );

  // A fetch word arriving during a flush belongs to a pre-flush request and is dropped too.
  assign if_rvalid_o = tag_valid & (tag_owner == OWN_IF) & ~flush_i;
  assign ls_rvalid_o = tag_valid & (tag_owner == OWN_LS);
  assign if_rdata_o  = if_rvalid_o ? rom_rdata_i : DW'(INST_NOP_WORD);
  assign ls_rdata_o  = ls_rvalid_o ? rom_rdata_i : '0;

endmodule
